// File: rtl/led_seq_pkg.sv
// Shared definitions for the LED sequencer controller: mode encoding and
// switch-bus bit positions.
package led_seq_pkg;

  typedef enum logic [1:0] {
    MODE_SHIFT = 2'b00,
    MODE_FLASH = 2'b01,
    MODE_HOLD  = 2'b10
  } mode_e;

  localparam int SW_RUN     = 0;
  localparam int SW_RATE_LO = 1;
  localparam int SW_RATE_HI = 2;
  localparam int SW_DIR     = 3;

endpackage

// File: rtl/btn_edge_detect.sv
// Push-button front end: 2-flop synchronizer, optional debounce filter
// (LED_SEQ_DEBOUNCE_EN) and a one-cycle press pulse on the accepted rising edge.
module btn_edge_detect #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clock,
  input  logic i_reset_n,
  input  logic i_btn,
  output logic o_press
);

  logic       r_sync1;
  logic       r_sync2;
  logic       r_prev;
  logic       r_armed;
  logic [1:0] r_fill;
  logic       w_level;

  always_ff @(posedge clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= i_btn;
      r_sync2 <= r_sync1;
    end
  end

`ifdef LED_SEQ_DEBOUNCE_EN
  localparam int NB_DB = $clog2(DEBOUNCE_CYCLES + 1);

  logic [NB_DB-1:0] r_db_cnt;
  logic             r_stable;

  // The level only moves once the synchronizer has disagreed with it for a full window.
  always_ff @(posedge clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_db_cnt <= '0;
      r_stable <= 1'b0;
    end else if (r_sync2 == r_stable) begin
      r_db_cnt <= '0;
    end else if (r_db_cnt == NB_DB'(DEBOUNCE_CYCLES - 1)) begin
      r_stable <= r_sync2;
      r_db_cnt <= '0;
    end else begin
      r_db_cnt <= r_db_cnt + 1'b1;
    end
  end

  assign w_level = r_stable;
`else
  logic w_unused_db;
  assign w_unused_db = (DEBOUNCE_CYCLES > 0);
  assign w_level     = r_sync2;
`endif

  // Edges are only honoured after the button has been seen released, so a
  // button held through reset release never produces a press.
  always_ff @(posedge clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_prev  <= 1'b0;
      r_armed <= 1'b0;
      r_fill  <= 2'd0;
    end else begin
      r_prev <= w_level;
      if (r_fill != 2'd2) r_fill <= r_fill + 2'd1;
      if (r_fill == 2'd2 && !r_sync2 && !w_level) r_armed <= 1'b1;
    end
  end

  assign o_press = r_armed & w_level & ~r_prev;

endmodule

// File: rtl/led_seq_ctrl.sv
// LED shift-register sequencer: switch-selected tick rate, push-button mode FSM
// (SHIFT/FLASH/HOLD) and registered per-tick commands. Optional LED_SEQ_DEBOUNCE_EN.
module led_seq_ctrl
  import led_seq_pkg::*;
#(
  parameter int                    NB_COUNTER      = 32,
  parameter int                    NB_SW           = 4,
  parameter logic [NB_COUNTER-1:0] R0_LIMIT        = NB_COUNTER'(2**(NB_COUNTER-10) - 1),
  parameter logic [NB_COUNTER-1:0] R1_LIMIT        = NB_COUNTER'(2**(NB_COUNTER-9) - 1),
  parameter logic [NB_COUNTER-1:0] R2_LIMIT        = NB_COUNTER'(2**(NB_COUNTER-8) - 1),
  parameter logic [NB_COUNTER-1:0] R3_LIMIT        = NB_COUNTER'(2**(NB_COUNTER-7) - 1),
  parameter int                    DEBOUNCE_CYCLES = 16
) (
  input  logic             clock,
  input  logic             i_reset_n,
  input  logic [NB_SW-1:0] i_sw,
  input  logic             i_btn,
  output logic             o_valid,
  output logic             o_shift_en,
  output logic             o_dir,
  output logic             o_flash,
  output logic [1:0]       o_mode
);

  logic [NB_COUNTER-1:0] r_count;
  logic [NB_COUNTER-1:0] w_limit;
  logic                  w_tick;
  logic                  w_press;
  mode_e                 r_mode;
  logic                  r_valid;
  logic                  r_shift_en;
  logic                  r_flash;
  logic                  r_dir;

  btn_edge_detect #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_btn (
    .clock    (clock),
    .i_reset_n(i_reset_n),
    .i_btn    (i_btn),
    .o_press  (w_press)
  );

  always_comb begin
    w_limit = R0_LIMIT;
    unique case (i_sw[SW_RATE_HI:SW_RATE_LO])
      2'd0: w_limit = R0_LIMIT;
      2'd1: w_limit = R1_LIMIT;
      2'd2: w_limit = R2_LIMIT;
      2'd3: w_limit = R3_LIMIT;
    endcase
  end

  assign w_tick = i_sw[SW_RUN] && (r_count == w_limit);

  // A count already past a newly selected, smaller limit wraps silently.
  always_ff @(posedge clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_count <= '0;
    end else if (i_sw[SW_RUN]) begin
      if (r_count >= w_limit) r_count <= '0;
      else                    r_count <= r_count + 1'b1;
    end
  end

  // Tick commands use the mode current at the tick; a coincident press lands afterwards.
  always_ff @(posedge clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_mode     <= MODE_SHIFT;
      r_valid    <= 1'b0;
      r_shift_en <= 1'b0;
      r_flash    <= 1'b0;
      r_dir      <= 1'b0;
    end else begin
      r_valid    <= w_tick;
      r_shift_en <= w_tick && (r_mode == MODE_SHIFT);
      r_flash    <= w_tick && (r_mode == MODE_FLASH);
      if (w_tick) r_dir <= i_sw[SW_DIR];
      case (r_mode)
        MODE_SHIFT: if (w_press) r_mode <= MODE_FLASH;
        MODE_FLASH: if (w_press) r_mode <= MODE_HOLD;
        MODE_HOLD:  if (w_press) r_mode <= MODE_SHIFT;
        default:    r_mode <= MODE_SHIFT;
      endcase
    end
  end

  assign o_valid    = r_valid;
  assign o_shift_en = r_shift_en;
  assign o_flash    = r_flash;
  assign o_dir      = r_dir;
  assign o_mode     = r_mode;

endmodule
